mem_and_wb: RTL and testbench



---
 rtl/mem_and_wb.sv | 43 ++++
 tb/tb_mem_and_wb.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_and_wb.sv
// rtl/mem_and_wb.sv - MIPS memory-access and write-back stage
// Word-organised data memory with combinational read and write-back select.
module mem_and_wb #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] AluResult,
  input  logic [31:0] ReadData2,
  input  logic        MemtoReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] WriteDataReg
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       read_data;

  // Byte offset and bits above the memory size are dropped: aligned, wrapping accesses.
  assign word_addr = AluResult[ADDR_W+1:2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (MemWrite) begin
      mem_q[word_addr] <= ReadData2;
    end
  end

  always_comb begin
    read_data = 32'h0;
    if (MemRead) begin
      read_data = mem_q[word_addr];
    end
  end

  assign WriteDataReg = MemtoReg ? read_data : AluResult;

endmodule

// File: tb/tb_mem_and_wb.sv
// tb/tb_mem_and_wb.sv - directed self-checking bench for mem_and_wb
module tb_mem_and_wb;

  logic        Clk;
  logic        Reset;
  logic [31:0] AluResult;
  logic [31:0] ReadData2;
  logic        MemtoReg;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteDataReg;

  int checks;
  int failures;

  mem_and_wb #(.DEPTH(256), .ADDR_W(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .AluResult    (AluResult),
    .ReadData2    (ReadData2),
    .MemtoReg     (MemtoReg),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .WriteDataReg (WriteDataReg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge Clk);
    AluResult = addr;
    ReadData2 = data;
    MemWrite  = 1'b1;
    @(posedge Clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    AluResult = addr;
    MemRead   = 1'b1;
    MemtoReg  = 1'b1;
    #1;
    check(tag, WriteDataReg, exp);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    Reset     = 1'b1;
    AluResult = 32'h0;
    ReadData2 = 32'h0;
    MemtoReg  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // 1: reset state
    AluResult = 32'h0;
    MemRead   = 1'b0;
    MemtoReg  = 1'b1;
    #1 check("rst_noread", WriteDataReg, 32'h0);
    MemRead = 1'b1;
    #1 check("rst_read0", WriteDataReg, 32'h0);
    read_word("rst_read_last", 32'd1020, 32'h0);

    // 2: ALU result bypass, no edge needed
    MemtoReg  = 1'b0;
    AluResult = 32'h1234_5678;
    MemRead   = 1'b1;
    #1 check("alu_bypass", WriteDataReg, 32'h1234_5678);

    // 3: store then load
    write_word(32'd8, 32'd32);
    read_word("load_8", 32'd8, 32'd32);
    read_word("load_12", 32'd12, 32'h0);

    // 4: alignment and wrap
    write_word(32'd4, 32'hDEAD_BEEF);
    read_word("align_7", 32'd7, 32'hDEAD_BEEF);
    read_word("wrap_depth", 32'd4 + 32'd1024, 32'hDEAD_BEEF);
    read_word("wrap_top", 32'h8000_0004, 32'hDEAD_BEEF);
    write_word(32'd1020, 32'hA5A5_0001);
    read_word("last_word", 32'd1020, 32'hA5A5_0001);
    read_word("last_wrap_neg", 32'hFFFF_FFFC, 32'hA5A5_0001);

    // 5: same-cycle read and write
    write_word(32'd16, 32'd5);
    @(negedge Clk);
    AluResult = 32'd16;
    MemRead   = 1'b1;
    MemtoReg  = 1'b1;
    MemWrite  = 1'b1;
    ReadData2 = 32'd9;
    #1 check("rw_before", WriteDataReg, 32'd5);
    @(posedge Clk);
    #1 check("rw_after", WriteDataReg, 32'd9);
    MemWrite  = 1'b0;
    ReadData2 = 32'd77;
    @(posedge Clk);
    #1 check("nowrite_hold", WriteDataReg, 32'd9);
    MemRead = 1'b0;
    #1 check("memread_off", WriteDataReg, 32'h0);
    MemtoReg = 1'b0;
    #1 check("memread_off_alu", WriteDataReg, 32'd16);

    // 6: reset mid-operation
    write_word(32'd8, 32'd32);
    @(negedge Clk);
    read_word("pre_reset", 32'd8, 32'd32);
    Reset = 1'b1;
    #1 check("reset_async", WriteDataReg, 32'h0);
    MemWrite  = 1'b1;
    ReadData2 = 32'd55;
    @(posedge Clk);
    #1 check("reset_wr_blocked", WriteDataReg, 32'h0);
    MemtoReg = 1'b0;
    #1 check("reset_alu", WriteDataReg, 32'd8);
    MemtoReg = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1 check("post_reset_prewr", WriteDataReg, 32'h0);
    @(posedge Clk);
    #1 check("post_reset_wr", WriteDataReg, 32'd55);
    MemWrite = 1'b0;
    read_word("reset_cleared_4", 32'd4, 32'h0);
    read_word("reset_cleared_16", 32'd16, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
